// File: rtl/ls_pkg.sv
// Shared definitions for the load/store arbiter: default widths, FSM encoding
// and the A-channel opcode bit position.
package ls_pkg;

   localparam int A_CHANNEL_SIZE_DEF = 55;
   localparam int D_CHANNEL_SIZE_DEF = 47;
   localparam int LOAD_WORD_DEF      = 22;
   localparam int STORE_WORD_DEF     = 54;
   localparam int RESP_WORD_DEF      = 45;
   localparam int MAX_OUT_DEF        = 4;
   localparam int A_OP_BIT_DEF       = A_CHANNEL_SIZE_DEF - 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SEND  = 2'd2
   } state_t;

   typedef enum logic {
      SRC_LOAD  = 1'b0,
      SRC_STORE = 1'b1
   } src_t;

   // The opcode (1 = store) always sits in the MSB of the A-channel word.
   function automatic int op_bit(input int a_size);
      return a_size - 1;
   endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-requester round-robin picker: on contention the requester that did not
// win last time is granted. req[0]/grant[0] = load, req[1]/grant[1] = store.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant
);

   always_comb begin
      grant = req;
      // last = 1 means store won previously, so load gets the tie.
      if (req == 2'b11) begin
         grant = last ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/ls_arbiter.sv
// Arbitrates load and store FIFOs onto a single A-channel master, limits the
// number of in-flight requests and forwards D-channel responses to a FIFO.
module ls_arbiter
   import ls_pkg::*;
#(
   parameter int A_CHANNEL_SIZE = A_CHANNEL_SIZE_DEF,
   parameter int D_CHANNEL_SIZE = D_CHANNEL_SIZE_DEF,
   parameter int LOAD_WORD      = LOAD_WORD_DEF,
   parameter int STORE_WORD     = STORE_WORD_DEF,
   parameter int RESP_WORD      = RESP_WORD_DEF,
   parameter int MAX_OUT        = MAX_OUT_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      load_fifo_empty_signal,
   input  logic                      store_fifo_empty_signal,
   input  logic [LOAD_WORD-1:0]      fifo_output_load,
   input  logic [STORE_WORD-1:0]     fifo_output_store,
   output logic                      read_load_fifo_signal,
   output logic                      read_store_fifo_signal,
   output logic [A_CHANNEL_SIZE-1:0] a_channel,
   output logic                      a_valid,
   input  logic                      a_ready,
   input  logic [D_CHANNEL_SIZE-1:0] d_channel,
   input  logic                      d_valid,
   output logic                      d_ready,
   input  logic                      response_fifo_full_signal,
   output logic                      response_fifo_signal,
   output logic [RESP_WORD-1:0]      fifo_input_response,
   output logic [3:0]                outstanding,
   output logic                      busy
);

   localparam int         OP_BIT    = op_bit(A_CHANNEL_SIZE);
   localparam logic [3:0] MAX_OUT_L = 4'(MAX_OUT);

   state_t                    state_q, state_d;
   src_t                      src_q, src_d;
   src_t                      last_q, last_d;
   logic [A_CHANNEL_SIZE-1:0] a_channel_q, a_channel_d;
   logic [3:0]                out_q, out_d;

   logic [1:0] req;
   logic [1:0] grant;
   logic       can_grant;
   logic       issue;
   logic       resp_accept;
   logic       d_unused;

   assign req       = {~store_fifo_empty_signal, ~load_fifo_empty_signal};
   assign can_grant = (out_q < MAX_OUT_L);
   assign d_unused  = ^d_channel[D_CHANNEL_SIZE-1:RESP_WORD];

   rr_pick2 u_pick (
      .req   (req),
      .last  (last_q),
      .grant (grant)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         src_q       <= SRC_LOAD;
         last_q      <= SRC_STORE;
         a_channel_q <= '0;
         out_q       <= '0;
      end else begin
         state_q     <= state_d;
         src_q       <= src_d;
         last_q      <= last_d;
         a_channel_q <= a_channel_d;
         out_q       <= out_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      src_d       = src_q;
      last_d      = last_q;
      a_channel_d = a_channel_q;
      case (state_q)
         ST_IDLE: begin
            if (can_grant && (grant != 2'b00)) begin
               src_d   = grant[1] ? SRC_STORE : SRC_LOAD;
               last_d  = src_d;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            // FIFO read data is valid this cycle, one cycle after the pulse.
            a_channel_d = '0;
            if (src_q == SRC_STORE) begin
               a_channel_d[STORE_WORD-1:0] = fifo_output_store;
               a_channel_d[OP_BIT]         = 1'b1;
            end else begin
               a_channel_d[LOAD_WORD-1:0]  = fifo_output_load;
            end
            state_d = ST_SEND;
         end
         ST_SEND: begin
            if (a_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      read_load_fifo_signal  = 1'b0;
      read_store_fifo_signal = 1'b0;
      if (!reset && (state_q == ST_IDLE) && can_grant) begin
         read_load_fifo_signal  = grant[0];
         read_store_fifo_signal = grant[1];
      end
      a_valid              = (state_q == ST_SEND);
      a_channel            = a_channel_q;
      d_ready              = ~response_fifo_full_signal;
      response_fifo_signal = resp_accept & ~reset;
      fifo_input_response  = d_channel[RESP_WORD-1:0];
      outstanding          = out_q;
      busy                 = (state_q != ST_IDLE) || (out_q != 4'd0);
   end

   assign issue       = (state_q == ST_SEND) && a_ready;
   assign resp_accept = d_valid && ~response_fifo_full_signal;

   // A response with nothing in flight is still forwarded; the count saturates at 0.
   always_comb begin
      out_d = out_q;
      if (issue && !resp_accept) begin
         out_d = out_q + 4'd1;
      end else if (!issue && resp_accept && (out_q != 4'd0)) begin
         out_d = out_q - 4'd1;
      end
   end

endmodule

// File: tb/tb_ls_arbiter.sv
// Directed bench for ls_arbiter with behavioural load/store FIFOs whose read
// data appears one cycle after the read pulse.
module tb_ls_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_empty, store_empty;
   logic [21:0] fifo_output_load  = '0;
   logic [53:0] fifo_output_store = '0;
   logic        read_load, read_store;
   logic [54:0] a_channel;
   logic        a_valid, a_ready;
   logic [46:0] d_channel;
   logic        d_valid, d_ready;
   logic        resp_full, resp_wr;
   logic [44:0] resp_data;
   logic [3:0]  outstanding;
   logic        busy;

   logic [21:0] ld_mem [0:31];
   logic [53:0] st_mem [0:31];
   int ld_wr = 0, ld_rd = 0, st_wr = 0, st_rd = 0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ls_arbiter dut (
      .clk                       (clk),
      .reset                     (reset),
      .load_fifo_empty_signal    (load_empty),
      .store_fifo_empty_signal   (store_empty),
      .fifo_output_load          (fifo_output_load),
      .fifo_output_store         (fifo_output_store),
      .read_load_fifo_signal     (read_load),
      .read_store_fifo_signal    (read_store),
      .a_channel                 (a_channel),
      .a_valid                   (a_valid),
      .a_ready                   (a_ready),
      .d_channel                 (d_channel),
      .d_valid                   (d_valid),
      .d_ready                   (d_ready),
      .response_fifo_full_signal (resp_full),
      .response_fifo_signal      (resp_wr),
      .fifo_input_response       (resp_data),
      .outstanding               (outstanding),
      .busy                      (busy)
   );

   assign load_empty  = (ld_wr == ld_rd);
   assign store_empty = (st_wr == st_rd);

   always @(posedge clk) begin
      if (read_load && (ld_wr != ld_rd)) begin
         fifo_output_load <= ld_mem[ld_rd];
         ld_rd <= ld_rd + 1;
      end
      if (read_store && (st_wr != st_rd)) begin
         fifo_output_store <= st_mem[st_rd];
         st_rd <= st_rd + 1;
      end
   end

   always @(posedge clk) begin
      if (a_valid && a_ready) $display("issue   a_channel=%h outstanding=%0d", a_channel, outstanding);
      if (resp_wr)            $display("respond data=%h outstanding=%0d", resp_data, outstanding);
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic push_load(input logic [21:0] d);
      ld_mem[ld_wr] = d;
      ld_wr++;
   endtask

   task automatic push_store(input logic [53:0] d);
      st_mem[st_wr] = d;
      st_wr++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; a_ready = 1'b0; d_valid = 1'b0; d_channel = '0; resp_full = 1'b0;
      repeat (3) tick();
      checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid got %0b required 0", a_valid); end
      checks++; if (a_channel !== 55'h0) begin errors++; $display("FAIL reset_a_channel got %h required 0", a_channel); end
      checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL reset_outstanding got %0d required 0", outstanding); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b required 0", busy); end
      checks++; if (resp_wr !== 1'b0) begin errors++; $display("FAIL reset_resp_wr got %0b required 0", resp_wr); end
      // A load waiting while reset is held must not be read.
      push_load(22'h2A5A5);
      #1;
      checks++; if (read_load !== 1'b0) begin errors++; $display("FAIL reset_read_gated got %0b required 0", read_load); end
      $display("test_reset done");
   endtask

   task automatic test_single_load();
      a_ready = 1'b1;
      reset = 1'b0;
      #1;
      checks++; if (read_load !== 1'b1 || read_store !== 1'b0) begin errors++; $display("FAIL single_read_T got L%0b S%0b required L1 S0", read_load, read_store); end
      tick();
      checks++; if (read_load !== 1'b0 || a_valid !== 1'b0) begin errors++; $display("FAIL single_fetch got rd%0b av%0b required rd0 av0", read_load, a_valid); end
      tick();
      checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL single_a_valid_T2 got %0b required 1", a_valid); end
      checks++; if (a_channel !== 55'h00000002A5A5) begin errors++; $display("FAIL single_a_channel got %h required 00000002a5a5", a_channel); end
      tick();
      checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL single_a_valid_drop got %0b required 0", a_valid); end
      checks++; if (outstanding !== 4'd1 || busy !== 1'b1) begin errors++; $display("FAIL single_outstanding got %0d busy %0b required 1 busy 1", outstanding, busy); end
      $display("test_single_load done");
   endtask

   task automatic test_round_robin();
      logic [21:0] lv [0:2];
      logic [53:0] sv [0:2];
      logic [54:0] exp_w;
      logic        exp_store;
      int          k;
      int          j;
      lv[0] = 22'h11111; lv[1] = 22'h22222; lv[2] = 22'h33333;
      sv[0] = 54'h0A_0000_0000_0001; sv[1] = 54'h0B_0000_0000_0002; sv[2] = 54'h0C_0000_0000_0003;
      do_reset();
      a_ready = 1'b1; d_valid = 1'b1; d_channel = 47'h1234; resp_full = 1'b0;
      for (int i = 0; i < 3; i++) begin
         push_load(lv[i]);
         push_store(sv[i]);
      end
      #1;
      for (int i = 0; i < 6; i++) begin
         exp_store = (i % 2) == 1;
         j = i / 2;
         k = 0;
         while (!(read_load || read_store) && k < 8) begin
            tick(); #1; k++;
         end
         checks++;
         if (read_store !== exp_store || read_load !== !exp_store) begin
            errors++;
            $display("FAIL rr_grant_%0d got L%0b S%0b required store=%0b", i, read_load, read_store, exp_store);
         end
         tick(); tick();
         exp_w = exp_store ? {1'b1, sv[j]} : {1'b0, 32'b0, lv[j]};
         checks++;
         if (a_valid !== 1'b1 || a_channel !== exp_w) begin
            errors++;
            $display("FAIL rr_word_%0d got av%0b %h required av1 %h", i, a_valid, a_channel, exp_w);
         end
         tick(); #1;
      end
      checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL rr_outstanding_floor got %0d required 0", outstanding); end
      checks++; if (resp_wr !== 1'b1) begin errors++; $display("FAIL rr_resp_at_zero got %0b required 1", resp_wr); end
      d_valid = 1'b0;
      $display("test_round_robin done");
   endtask

   task automatic test_max_out();
      int n;
      do_reset();
      a_ready = 1'b1; d_valid = 1'b0; d_channel = 47'h0_0000_0000_0055; resp_full = 1'b0;
      for (int i = 0; i < 5; i++) push_load(22'h00100 + 22'(i));
      #1;
      n = 0;
      repeat (30) begin
         if (read_load) n++;
         tick(); #1;
      end
      checks++; if (n !== 4) begin errors++; $display("FAIL maxout_reads got %0d required 4", n); end
      checks++; if (outstanding !== 4'd4) begin errors++; $display("FAIL maxout_count got %0d required 4", outstanding); end
      d_valid = 1'b1;
      #1;
      checks++; if (resp_wr !== 1'b1 || resp_data !== 45'h55) begin errors++; $display("FAIL maxout_resp got wr%0b %h required wr1 55", resp_wr, resp_data); end
      tick();
      d_valid = 1'b0;
      #1;
      checks++; if (outstanding !== 4'd3) begin errors++; $display("FAIL maxout_dec got %0d required 3", outstanding); end
      n = 0;
      repeat (20) begin
         if (read_load) n++;
         tick(); #1;
      end
      checks++; if (n !== 1 || outstanding !== 4'd4) begin errors++; $display("FAIL maxout_one_more got reads %0d out %0d required reads 1 out 4", n, outstanding); end
      d_valid = 1'b1;
      repeat (4) tick();
      d_valid = 1'b0;
      #1;
      checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL maxout_drain got %0d required 0", outstanding); end
      $display("test_max_out done");
   endtask

   task automatic test_backpressure();
      logic [54:0] exp_w;
      exp_w = {1'b1, 54'h2_DEAD_BEEF_CAFE};
      a_ready = 1'b0;
      push_store(54'h2_DEAD_BEEF_CAFE);
      #1;
      checks++; if (read_store !== 1'b1) begin errors++; $display("FAIL bp_read got %0b required 1", read_store); end
      tick(); tick();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (a_valid !== 1'b1 || a_channel !== exp_w) begin
            errors++;
            $display("FAIL bp_hold_%0d got av%0b %h required av1 %h", i, a_valid, a_channel, exp_w);
         end
         tick();
      end
      a_ready = 1'b1;
      #1;
      checks++; if (a_valid !== 1'b1 || a_channel !== exp_w || outstanding !== 4'd0) begin errors++; $display("FAIL bp_last got av%0b %h out %0d required av1 %h out 0", a_valid, a_channel, outstanding, exp_w); end
      tick();
      checks++; if (a_valid !== 1'b0 || outstanding !== 4'd1) begin errors++; $display("FAIL bp_issue got av%0b out %0d required av0 out 1", a_valid, outstanding); end
      a_ready = 1'b0;
      $display("test_backpressure done");
   endtask

   task automatic test_resp_full();
      resp_full = 1'b1; d_valid = 1'b1; d_channel = 47'h2ABC_DEF0_1234;
      #1;
      checks++; if (d_ready !== 1'b0 || resp_wr !== 1'b0) begin errors++; $display("FAIL full_block got rdy%0b wr%0b required rdy0 wr0", d_ready, resp_wr); end
      tick();
      checks++; if (outstanding !== 4'd1) begin errors++; $display("FAIL full_hold got %0d required 1", outstanding); end
      resp_full = 1'b0;
      #1;
      checks++; if (d_ready !== 1'b1 || resp_wr !== 1'b1) begin errors++; $display("FAIL full_release got rdy%0b wr%0b required rdy1 wr1", d_ready, resp_wr); end
      checks++; if (resp_data !== 45'h0ABC_DEF0_1234) begin errors++; $display("FAIL full_data got %h required 0abcdef01234", resp_data); end
      tick();
      d_valid = 1'b0;
      checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL full_dec got %0d required 0", outstanding); end
      $display("test_resp_full done");
   endtask

   task automatic test_reset_in_send();
      a_ready = 1'b0;
      push_load(22'h3C3C3);
      #1;
      checks++; if (read_load !== 1'b1) begin errors++; $display("FAIL rsend_read got %0b required 1", read_load); end
      tick(); tick();
      checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL rsend_in_send got %0b required 1", a_valid); end
      reset = 1'b1;
      tick();
      checks++; if (a_valid !== 1'b0 || outstanding !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL rsend_cleared got av%0b out %0d busy %0b required av0 out0 busy0", a_valid, outstanding, busy); end
      checks++; if (a_channel !== 55'h0) begin errors++; $display("FAIL rsend_a_channel got %h required 0", a_channel); end
      reset = 1'b0;
      #1;
      checks++; if (read_load !== 1'b0 || read_store !== 1'b0) begin errors++; $display("FAIL rsend_no_read got L%0b S%0b required L0 S0", read_load, read_store); end
      tick();
      checks++; if (a_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rsend_idle got av%0b busy %0b required av0 busy0", a_valid, busy); end
      $display("test_reset_in_send done");
   endtask

   initial begin
      test_reset();
      test_single_load();
      test_round_robin();
      test_max_out();
      test_backpressure();
      test_resp_full();
      test_reset_in_send();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
